run_sequencer: RTL and testbench

Programmable run sequencer that sits above the SPI and task front-ends of the electrochemistry chip controller. It issues `trigger_config` and `trigger_task` pulses from a small host-loaded step program. Between steps it waits for the matching done flags or for programmed delays, and it repeats the whole program a set number of times. It replaces host-timed triggering and adds an optional watchdog.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_prog_mem.sv | 29 ++
 rtl/run_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_run_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the run sequencer: opcodes, FSM states and step-word layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    // Step word layout: opcode in the top two bits, argument below it.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 30;
    localparam int ARG_W  = 30;

    typedef enum logic [1:0] {
        OP_END    = 2'b00,
        OP_CONFIG = 2'b01,
        OP_TASK   = 2'b10,
        OP_WAIT   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_FINISH
    } state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Step program store: DEPTH x 32 register array, host-loaded.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH];

    // Synchronous write; contents survive reset so a loaded program is kept.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: steps a host-loaded program, issuing config/task triggers and repeating it n_loops times.
// Latency: start -> first trigger 2 cycles; done edge -> next trigger 2 cycles; WAIT N adds N+1 cycles.
// Backpressure: none; waits on done edges, abort returns to IDLE next edge. Watchdog built only with SEQ_TIMEOUT_EN.
module run_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_wr,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [15:0]   n_loops,
    input  logic [31:0]   timeout_cycles,
    input  logic          start,
    input  logic          abort,
    input  logic          done_spi,
    input  logic          done_task,
    output logic          trigger_config,
    output logic          trigger_task,
    output logic          busy,
    output logic          run_done,
    output logic          error,
    output logic [AW-1:0] step_idx,
    output logic [15:0]   loop_idx
);

    state_e           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [15:0]      loop_q, loop_d;
    logic [15:0]      nloops_q, nloops_d;
    op_e              op_q, op_d;
    logic [ARG_W-1:0] cnt_q, cnt_d;
    logic             done_spi_q, done_task_q;

    logic [31:0]      rd_data;
    op_e              fetch_op;
    logic [ARG_W-1:0] fetch_arg;
    logic             spi_edge, task_edge, done_hit;
    logic             trig_cfg, trig_task, fin_pulse;
    logic             do_adv, do_eop;

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic [31:0] to_q, to_d;
    logic [31:0] wd_inc;
    logic        error_q, error_d;

    assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 32'd1;
    assign error  = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles;
    assign error          = 1'b0;
`endif

    // Program writes only land while idle so a running program cannot be altered.
    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (prog_wr && (state_q == S_IDLE)),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_q),
        .rd_data (rd_data)
    );

    assign fetch_op  = op_e'(rd_data[OP_MSB:OP_LSB]);
    assign fetch_arg = rd_data[ARG_W-1:0];

    // Rising edges against a registered copy: a level already high never counts as completion.
    assign spi_edge  = done_spi  && !done_spi_q;
    assign task_edge = done_task && !done_task_q;
    assign done_hit  = (op_q == OP_CONFIG) ? spi_edge : task_edge;

    // Next-state, datapath updates and pulse outputs; abort overrides everything at the end.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        loop_d    = loop_q;
        nloops_d  = nloops_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        trig_cfg  = 1'b0;
        trig_task = 1'b0;
        fin_pulse = 1'b0;
        do_adv    = 1'b0;
        do_eop    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wd_d      = wd_q;
        to_d      = to_q;
        error_d   = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pc_d     = '0;
                    loop_d   = '0;
                    nloops_d = (n_loops == 16'd0) ? 16'd1 : n_loops;
`ifdef SEQ_TIMEOUT_EN
                    to_d     = timeout_cycles;
                    error_d  = 1'b0;
`endif
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                op_d = fetch_op;
                case (fetch_op)
                    OP_CONFIG, OP_TASK: state_d = S_ISSUE;
                    OP_WAIT: begin
                        if (fetch_arg != '0) begin
                            cnt_d   = fetch_arg;
                            state_d = S_DELAY;
                        end else begin
                            do_adv = 1'b1;
                        end
                    end
                    default: do_eop = 1'b1;
                endcase
            end
            S_ISSUE: begin
                trig_cfg  = (op_q == OP_CONFIG);
                trig_task = (op_q == OP_TASK);
`ifdef SEQ_TIMEOUT_EN
                wd_d      = '0;
`endif
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_hit) begin
                    do_adv = 1'b1;
                end
`ifdef SEQ_TIMEOUT_EN
                wd_d = wd_inc;
                // A done edge in the very cycle the limit is hit still counts as success.
                if (!done_hit && (to_q != '0) && (wd_inc >= to_q)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DELAY: begin
                if (cnt_q <= ARG_W'(1)) begin
                    do_adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - ARG_W'(1);
                end
            end
            S_FINISH: begin
                fin_pulse = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_adv) begin
            if (pc_q == AW'(DEPTH - 1)) begin
                do_eop = 1'b1;
            end else begin
                pc_d    = pc_q + AW'(1);
                state_d = S_FETCH;
            end
        end

        if (do_eop) begin
            if ((32'(loop_q) + 32'd1) < 32'(nloops_q)) begin
                loop_d  = loop_q + 16'd1;
                pc_d    = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_FINISH;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            pc_d      = pc_q;
            loop_d    = loop_q;
            trig_cfg  = 1'b0;
            trig_task = 1'b0;
            fin_pulse = 1'b0;
`ifdef SEQ_TIMEOUT_EN
            error_d   = error_q;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            loop_q      <= '0;
            nloops_q    <= '0;
            op_q        <= OP_END;
            cnt_q       <= '0;
            done_spi_q  <= 1'b0;
            done_task_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            loop_q      <= loop_d;
            nloops_q    <= nloops_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            done_spi_q  <= done_spi;
            done_task_q <= done_task;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog counter, sampled limit and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            to_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            to_q    <= to_d;
            error_q <= error_d;
        end
    end
`endif

    assign trigger_config = trig_cfg;
    assign trigger_task   = trig_task;
    assign run_done       = fin_pulse;
    assign busy           = (state_q != S_IDLE);
    assign step_idx       = pc_q;
    assign loop_idx       = loop_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: table-driven program runs plus hand-written corner sequences.
// Latency: expected pulse cycles come from a timeline model of the step program.
// Backpressure: a done responder answers each trigger after a programmable delay.
`timescale 1ns/1ps
module tb_run_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [1:0] C_END = 2'b00, C_CFG = 2'b01, C_TSK = 2'b10, C_WAIT = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_wr = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [15:0]   n_loops = 16'd1;
    logic [31:0]   timeout_cycles = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          done_spi = 1'b0;
    logic          done_task = 1'b0;
    logic          trigger_config, trigger_task, busy, run_done, error;
    logic [AW-1:0] step_idx;
    logic [15:0]   loop_idx;

    run_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .prog_wr(prog_wr), .prog_addr(prog_addr), .prog_data(prog_data),
        .n_loops(n_loops), .timeout_cycles(timeout_cycles), .start(start), .abort(abort),
        .done_spi(done_spi), .done_task(done_task), .trigger_config(trigger_config),
        .trigger_task(trigger_task), .busy(busy), .run_done(run_done), .error(error),
        .step_idx(step_idx), .loop_idx(loop_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; int lp; int pc; } ev_t;
    typedef struct { logic [3:0][31:0] prog; int nl; int dly; int exp_cfg; int exp_task; } vec_t;

    ev_t         exp_q[$];
    vec_t        vecs[4];
    logic [31:0] img[DEPTH];
    int total = 0, bad = 0;
    int cnt_cfg = 0, cnt_task = 0, cnt_done = 0;
    int resp_dly = 1, spi_due = -1, task_due = -1;
    bit resp_en = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] op, input int arg);
        logic [29:0] a;
        a = 30'(arg);
        return {op, a};
    endfunction

    // Timeline model: FETCH at f; CONFIG/TASK trigger at f+1, next FETCH f+2+dly;
    // WAIT N next FETCH f+N+1; END or step DEPTH-1 ends the pass; run_done where the next FETCH would be.
    function automatic void model(input int t0, input int nl, input int dly);
        int f, nle, lastpc;
        logic [31:0] w;
        f = t0 + 1;
        nle = (nl == 0) ? 1 : nl;
        lastpc = 0;
        for (int lp = 0; lp < nle; lp++) begin
            for (int pc = 0; pc < DEPTH; pc++) begin
                w = img[pc];
                lastpc = pc;
                if (w[31:30] == C_CFG || w[31:30] == C_TSK) begin
                    exp_q.push_back('{kind: (w[31:30] == C_CFG) ? 0 : 1, cyc: f + 1, lp: lp, pc: pc});
                    f = f + 2 + dly;
                end else if (w[31:30] == C_WAIT) begin
                    f = f + 1 + int'(w[29:0]);
                end else begin
                    f = f + 1;
                    break;
                end
            end
        end
        exp_q.push_back('{kind: 2, cyc: f, lp: nle - 1, pc: lastpc});
    endfunction

    task automatic handle(input int kind);
        ev_t e;
        if (kind == 0) begin cnt_cfg++; spi_due = cyc + resp_dly; end
        if (kind == 1) begin cnt_task++; task_due = cyc + resp_dly; end
        if (kind == 2) cnt_done++;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            check("loop_idx", loop_idx, e.lp);
            check("step_idx", step_idx, e.pc);
        end
    endtask

    // Output monitor on the falling edge: every pulse is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (trigger_config) handle(0);
            if (trigger_task)   handle(1);
            if (run_done)       handle(2);
        end
    end

    // Done responder: one-cycle done pulse resp_dly cycles after each trigger.
    initial forever begin
        @(posedge clk); #1;
        if (resp_en) begin
            done_spi  = (cyc == spi_due);
            done_task = (cyc == task_due);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish by 500000ns");
        $fatal(1, "bench timeout");
    end

    task automatic at_cycle(input int c);
        forever begin
            @(posedge clk); #1;
            if (cyc >= c) break;
        end
    endtask

    task automatic prog_write(input int a, input logic [31:0] d, input bit accepted);
        @(posedge clk); #1;
        prog_wr = 1'b1; prog_addr = AW'(a); prog_data = d;
        @(posedge clk); #1;
        prog_wr = 1'b0;
        if (accepted) img[a] = d;
    endtask

    task automatic do_start(output int t, input int nl, input int dly, input bit use_model);
        @(posedge clk); #1;
        start = 1'b1;
        t = cyc;
        if (use_model) model(t, nl, dly);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic clear_counts();
        cnt_cfg = 0; cnt_task = 0; cnt_done = 0;
    endtask

    task automatic set_vec(input int i, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int nl, input int dly, input int ec, input int et);
        vecs[i].prog[0] = w0; vecs[i].prog[1] = w1; vecs[i].prog[2] = w2; vecs[i].prog[3] = w3;
        vecs[i].nl = nl; vecs[i].dly = dly; vecs[i].exp_cfg = ec; vecs[i].exp_task = et;
    endtask

    initial begin
        int t, t2, tt;
        set_vec(0, mk(C_CFG, 0), mk(C_TSK, 0), mk(C_END, 0), mk(C_END, 0), 1, 5, 1, 1);
        set_vec(1, mk(C_WAIT, 10), mk(C_TSK, 0), mk(C_END, 0), mk(C_END, 0), 3, 3, 0, 3);
        set_vec(2, mk(C_TSK, 0), mk(C_WAIT, 0), mk(C_CFG, 0), mk(C_END, 0), 0, 2, 1, 1);
        set_vec(3, mk(C_CFG, 0), mk(C_WAIT, 1), mk(C_CFG, 0), mk(C_END, 0), 2, 1, 4, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_trig_cfg", trigger_config, 0);
        check("rst_trig_task", trigger_task, 0);
        check("rst_run_done", run_done, 0);
        check("rst_error", error, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_loop_idx", loop_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven program runs; n_loops is disturbed after start to prove it was sampled.
        for (int i = 0; i < 4; i++) begin
            for (int a = 0; a < 4; a++) prog_write(a, vecs[i].prog[a], 1'b1);
            n_loops = 16'(vecs[i].nl);
            resp_dly = vecs[i].dly;
            clear_counts();
            do_start(t, vecs[i].nl, vecs[i].dly, 1'b1);
            n_loops = 16'd0;
            drain("vec");
            check("vec_cfg_count", cnt_cfg, vecs[i].exp_cfg);
            check("vec_task_count", cnt_task, vecs[i].exp_task);
            check("vec_done_count", cnt_done, 1);
        end

        // done_task already high before ISSUE; first real edge 4 cycles after the trigger.
        prog_write(0, mk(C_TSK, 0), 1'b1);
        prog_write(1, mk(C_END, 0), 1'b1);
        resp_en = 1'b0;
        done_task = 1'b1;
        n_loops = 16'd1;
        repeat (3) @(posedge clk);
        do_start(t, 1, 4, 1'b1);
        at_cycle(t + 3);
        done_spi = 1'b1;                 // non-matching edge must be ignored
        at_cycle(t + 4);
        done_spi = 1'b0;
        done_task = 1'b0;
        at_cycle(t + 5);
        check("level_no_early_adv", busy, 1);
        at_cycle(t + 6);
        done_task = 1'b1;
        drain("level");
        done_task = 1'b0;
        resp_en = 1'b1;

        // Abort during a long WAIT, together with start.
        prog_write(0, mk(C_WAIT, 100), 1'b1);
        prog_write(1, mk(C_TSK, 0), 1'b1);
        prog_write(2, mk(C_END, 0), 1'b1);
        clear_counts();
        resp_dly = 2;
        do_start(t, 1, 0, 1'b0);
        at_cycle(t + 20);
        check("abort_busy_before", busy, 1);
        abort = 1'b1; start = 1'b1;
        at_cycle(t + 21);
        abort = 1'b0; start = 1'b0;
        check("abort_busy_next", busy, 0);
        at_cycle(t + 140);
        check("abort_busy_later", busy, 0);
        check("abort_task_count", cnt_task, 0);
        check("abort_done_count", cnt_done, 0);

        // Watchdog on a CONFIG whose done never arrives.
        prog_write(0, mk(C_CFG, 0), 1'b1);
        prog_write(1, mk(C_END, 0), 1'b1);
        resp_en = 1'b0;
        clear_counts();
        timeout_cycles = 32'd20;
        do_start(t, 1, 0, 1'b0);
        exp_q.push_back('{kind: 0, cyc: t + 2, lp: 0, pc: 0});
        timeout_cycles = 32'd5;          // must not affect the run in progress
`ifdef SEQ_TIMEOUT_EN
        at_cycle(t + 22);
        check("to_error_before", error, 0);
        check("to_busy_before", busy, 1);
        at_cycle(t + 23);
        check("to_error_set", error, 1);
        check("to_busy_after", busy, 0);
        at_cycle(t + 30);
        check("to_error_sticky", error, 1);
        check("to_done_count", cnt_done, 0);
        do_start(t2, 1, 0, 1'b0);
        exp_q.push_back('{kind: 0, cyc: t2 + 2, lp: 0, pc: 0});
        check("to_error_cleared", error, 0);
        at_cycle(t2 + 3);
        abort = 1'b1;
        at_cycle(t2 + 4);
        abort = 1'b0;
        check("to_abort_busy", busy, 0);
`else
        at_cycle(t + 40);
        check("nowd_error", error, 0);
        check("nowd_busy", busy, 1);
        abort = 1'b1;
        at_cycle(t + 41);
        abort = 1'b0;
        check("nowd_abort_busy", busy, 0);
        check("nowd_error_after", error, 0);
`endif
        check("to_pending", exp_q.size(), 0);
        exp_q.delete();
        resp_en = 1'b1;

        // Writes while busy are dropped; a rerun repeats the original sequence.
        prog_write(0, mk(C_CFG, 0), 1'b1);
        prog_write(1, mk(C_TSK, 0), 1'b1);
        prog_write(2, mk(C_END, 0), 1'b1);
        clear_counts();
        resp_dly = 3;
        n_loops = 16'd1;
        do_start(t, 1, 3, 1'b1);
        prog_write(0, mk(C_WAIT, 5), 1'b0);
        prog_write(1, mk(C_END, 0), 1'b0);
        drain("wrbusy_run1");
        do_start(tt, 1, 3, 1'b1);
        drain("wrbusy_run2");
        check("wrbusy_cfg_count", cnt_cfg, 2);
        check("wrbusy_task_count", cnt_task, 2);

        // Full program with no END wraps to end-of-pass after the last step.
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 0)              prog_write(a, mk(C_TSK, 0), 1'b1);
            else if (a == DEPTH - 1) prog_write(a, mk(C_CFG, 0), 1'b1);
            else                     prog_write(a, mk(C_WAIT, (a % 2 == 1) ? 0 : 2), 1'b1);
        end
        clear_counts();
        resp_dly = 2;
        n_loops = 16'd2;
        do_start(t, 2, 2, 1'b1);
        drain("full16");
        check("full16_cfg_count", cnt_cfg, 2);
        check("full16_task_count", cnt_task, 2);
        check("full16_done_count", cnt_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
